// File: rtl/signed_mult_pkg.sv
// Shared types and constants for the arbitrated signed multiplier.
// No logic of its own; imported by the pipeline and the arbiter top.
package signed_mult_pkg;
  typedef logic signed [7:0]  operand_t;
  typedef logic signed [15:0] product_t;
  localparam int MULT_LAT = 2;
endpackage

// File: rtl/signed_mult_pipe.sv
// Two-stage multiply pipeline: S1 captures operands+ID, S2 captures product+ID.
// Latency 2 cycles; a global stall freezes both stages so S2 holds its result.
module signed_mult_pipe
  import signed_mult_pkg::*;
#(
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  operand_t        in_a,
  input  operand_t        in_b,
  input  logic [ID_W-1:0] in_id,
  input  logic            stall,
  output logic            out_valid,
  output product_t        out_p,
  output logic [ID_W-1:0] out_id
);

  logic            s1_vld;
  operand_t        s1_a;
  operand_t        s1_b;
  logic [ID_W-1:0] s1_id;
  logic            s2_vld;
  product_t        s2_p;
  logic [ID_W-1:0] s2_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_id  <= '0;
      s2_vld <= 1'b0;
      s2_p   <= '0;
      s2_id  <= '0;
    end else if (!stall) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_id <= in_id;
      end
      s2_vld <= s1_vld;
      // Data only moves with a real op, so bubbles leave the last result visible.
      if (s1_vld) begin
        s2_p  <= product_t'(s1_a) * product_t'(s1_b);
        s2_id <= s1_id;
      end
    end
  end

  assign out_valid = s2_vld;
  assign out_p     = s2_p;
  assign out_id    = s2_id;

endmodule

// File: rtl/signed_mult_arbiter.sv
// Arbitrates N_REQ requesters onto one 2-cycle signed multiplier; results tagged by ID.
// Global stall on result backpressure; MULT_ARB_RR_EN selects round-robin over fixed priority.
module signed_mult_arbiter
  import signed_mult_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*8-1:0] req_a,
  input  logic [N_REQ*8-1:0] req_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [15:0]        res_data,
  output logic [ID_W-1:0]    res_id,
  output logic               idle
);

  logic            stall;
  logic            gnt_found;
  logic            gnt_vld;
  logic [ID_W-1:0] gnt_idx;
  logic            s1_vld;
  logic            out_vld;
  product_t        out_p;
  logic [ID_W-1:0] out_id;

  assign stall = out_vld & ~res_ready;

`ifdef MULT_ARB_RR_EN
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cand;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % N_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= ID_W'((int'(gnt_idx) + 1) % N_REQ);
    end
  end
`else
  // Scan downward so the lowest valid index is the last (winning) assignment.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(i);
      end
    end
  end
`endif

  // rst_n gates the grant so requesters see no acceptance while in reset.
  assign gnt_vld = gnt_found & ~stall & rst_n;

  always_comb begin
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  // Shadow of the pipeline's S1 valid, used only for idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
    end else if (!stall) begin
      s1_vld <= gnt_vld;
    end
  end

  signed_mult_pipe #(.ID_W(ID_W)) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (gnt_vld),
    .in_a      (operand_t'(req_a[{gnt_idx, 3'b000} +: 8])),
    .in_b      (operand_t'(req_b[{gnt_idx, 3'b000} +: 8])),
    .in_id     (gnt_idx),
    .stall     (stall),
    .out_valid (out_vld),
    .out_p     (out_p),
    .out_id    (out_id)
  );

  assign res_valid = out_vld;
  assign res_data  = out_p;
  assign res_id    = out_id;
  assign idle      = ~s1_vld & ~out_vld;

endmodule

// File: tb/tb_signed_mult_arbiter.sv
// Directed + randomised self-checking bench for signed_mult_arbiter (N_REQ=4).
module tb_signed_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [1:0]  res_id;
  logic        idle;

  int err_cnt = 0;
  int chk_cnt = 0;

  typedef struct {
    int          id;
    logic [15:0] p;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] hs;

  signed_mult_arbiter #(.N_REQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    chk_cnt++;
    if (got !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp_v);
    end
  endtask

  function automatic logic [15:0] model_mult(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  // Negedge sampling for the random phase: log issues, then score returns.
  task automatic sample_cycle();
    exp_t e;
    int   idx;
    hs = req_valid & req_ready;
    check("t6_onehot", 32'($onehot0(req_ready)), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) begin
        e.id = i;
        e.p  = model_mult(req_a[i*8 +: 8], req_b[i*8 +: 8]);
        sb.push_back(e);
      end
    end
    if (res_valid && res_ready) begin
      idx = -1;
      for (int k = 0; k < sb.size(); k++)
        if (idx < 0 && sb[k].id == int'(res_id)) idx = k;
      check("t6_expected", 32'(idx >= 0), 32'd1);
      if (idx >= 0) begin
        check("t6_data", 32'(res_data), 32'(sb[idx].p));
        sb.delete(idx);
      end
    end
  endtask

  initial begin
    logic [15:0] t3_exp [3];
    logic [3:0]  exp_rdy;
    int          guard;

    t3_exp[0] = 16'h4000;
    t3_exp[1] = 16'hC080;
    t3_exp[2] = 16'h3F01;

    rst_n     = 1'b0;
    req_valid = 4'b0001;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    hs        = '0;

    // Reset state, with a requester already asserting valid
    @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data",  32'(res_data),  32'd0);
    check("rst_res_id",    32'(res_id),    32'd0);
    check("rst_idle",      32'(idle),      32'd1);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    rst_n     = 1'b1;

    // Single op: -3 * 7 = -21
    @(posedge clk); #1;
    set_req(0, 8'hFD, 8'h07);
    req_valid = 4'b0001;
    @(negedge clk);
    check("t2_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    check("t2_not_yet", 32'(res_valid), 32'd0);
    check("t2_busy",    32'(idle),      32'd0);
    @(posedge clk);
    @(negedge clk);
    check("t2_valid", 32'(res_valid), 32'd1);
    check("t2_data",  32'(res_data),  32'h0000_FFEB);
    check("t2_id",    32'(res_id),    32'd0);
    @(posedge clk); #1;

    // Extremes back-to-back from requester 1
    for (int k = 0; k < 5; k++) begin
      if (k == 0) set_req(1, 8'h80, 8'h80);
      if (k == 1) set_req(1, 8'h80, 8'h7F);
      if (k == 2) set_req(1, 8'h7F, 8'h7F);
      req_valid = (k < 3) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      if (k < 3) check("t3_ready", 32'(req_ready), 32'h2);
      if (k >= 2) begin
        check("t3_valid", 32'(res_valid), 32'd1);
        check("t3_data",  32'(res_data),  32'(t3_exp[k-2]));
        check("t3_id",    32'(res_id),    32'd1);
      end
      @(posedge clk); #1;
    end
    req_valid = 4'b0000;
    @(posedge clk); #1;

    // Backpressure with S2 full and a third op pending
    set_req(2, 8'h02, 8'h03);
    req_valid = 4'b0100;
    @(negedge clk);
    check("t4_rdy_x", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    set_req(2, 8'hFC, 8'h05);
    @(negedge clk);
    check("t4_rdy_y", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    res_ready = 1'b0;
    set_req(2, 8'h07, 8'hF8);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t4_hold_valid", 32'(res_valid), 32'd1);
      check("t4_hold_data",  32'(res_data),  32'h0006);
      check("t4_hold_id",    32'(res_id),    32'd2);
      check("t4_stall_rdy",  32'(req_ready), 32'h0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("t4_rdy_z", 32'(req_ready), 32'h4);
    check("t4_data_x", 32'(res_data), 32'h0006);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    check("t4_data_y", 32'(res_data), 32'h0000_FFEC);
    check("t4_id_y",   32'(res_id),   32'd2);
    @(posedge clk);
    @(negedge clk);
    check("t4_data_z", 32'(res_data), 32'h0000_FFC8);
    check("t4_valid_z", 32'(res_valid), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("t4_no_dup", 32'(res_valid), 32'd0);
    @(posedge clk); #1;

    // Reset mid-stream: two ops in flight, then reset
    set_req(3, 8'h05, 8'h05);
    req_valid = 4'b1000;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("t1_res_valid", 32'(res_valid), 32'd0);
    check("t1_res_data",  32'(res_data),  32'd0);
    check("t1_idle",      32'(idle),      32'd1);
    check("t1_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    rst_n     = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t1_no_ghost", 32'(res_valid), 32'd0);
      @(posedge clk); #1;
    end
    check("t1_idle_after", 32'(idle), 32'd1);

    // Arbitration with all requesters valid
    for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1), 8'h01);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
`ifdef MULT_ARB_RR_EN
      exp_rdy = 4'b0001 << (k % 4);
`else
      exp_rdy = (k < 4) ? 4'b0001 : 4'b0010;
`endif
      @(negedge clk);
      check("t5_grant", 32'(req_ready), 32'(exp_rdy));
      @(posedge clk); #1;
`ifndef MULT_ARB_RR_EN
      if (k == 3) req_valid[0] = 1'b0;
`endif
    end
    req_valid = 4'b0000;
    repeat (4) @(posedge clk);
    #1;

    // Random traffic against an ID-keyed scoreboard
    hs = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (hs[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          set_req(i, ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)));
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      sample_cycle();
      @(posedge clk); #1;
    end
    guard = 0;
    res_ready = 1'b1;
    while (guard < 200 && !(sb.size() == 0 && req_valid == 4'b0000 && idle)) begin
      for (int i = 0; i < 4; i++) if (hs[i]) req_valid[i] = 1'b0;
      @(negedge clk);
      sample_cycle();
      @(posedge clk); #1;
      guard++;
    end
    check("t6_drained", 32'(sb.size()), 32'd0);
    check("t6_all_issued", 32'(req_valid), 32'd0);
    check("t6_idle", 32'(idle), 32'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
